// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 3-stage RGB565/888 to gray/YCbCr/binary/bypass converter with per-frame luma stats
module rgb2ycbcr_pipe #(
  parameter int IN_FMT = 0,
  parameter int SUM_W = 32,
  parameter int CNT_W = 22,
  localparam int DW = (IN_FMT == 1) ? 24 : 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_thresh,
  input  logic             RGB_de,
  input  logic             RGB_hsync,
  input  logic             RGB_vsync,
  input  logic [DW-1:0]    RGB_data,
  output logic             out_de,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [23:0]      out_data,
  output logic [SUM_W-1:0] lum_sum,
  output logic [CNT_W-1:0] lum_cnt,
  output logic             lum_valid
);
  logic [7:0] r, g, b;
  if (IN_FMT == 1) begin : g_888
    assign {r, g, b} = RGB_data;
  end else begin : g_565
    assign r = {RGB_data[15:11], RGB_data[13:11]};
    assign g = {RGB_data[10:5], RGB_data[6:5]};
    assign b = {RGB_data[4:0], RGB_data[2:0]};
  end
  logic vs_q, rise;
  logic [1:0] act_mode_q, mode_d;
  logic [7:0] act_thresh_q, thresh_d;
  logic signed [17:0] rs, gs, bs;
  logic signed [17:0] p_d [9];
  logic signed [17:0] p_q [9];
  logic [1:0] m1_q, m2_q;
  logic [7:0] t1_q, t2_q;
  logic [23:0] rgb1_q, rgb2_q;
  logic [2:0] sync1_q, sync2_q, sync3_q;
  logic signed [9:0] y2_q, cb2_q, cr2_q;
  logic [7:0] y_c, cb_c, cr_c, y3_q;
  logic [23:0] data_d, data3_q;
  // the edge that starts a frame also selects the settings for its own pixel
  assign rise = RGB_vsync & ~vs_q;
  assign mode_d = rise ? cfg_mode : act_mode_q;
  assign thresh_d = rise ? cfg_thresh : act_thresh_q;
  assign rs = {10'd0, r};
  assign gs = {10'd0, g};
  assign bs = {10'd0, b};
  always_comb begin
    p_d[0] = 18'sd77 * rs;
    p_d[1] = 18'sd150 * gs;
    p_d[2] = 18'sd29 * bs;
    p_d[3] = -18'sd43 * rs;
    p_d[4] = -18'sd85 * gs;
    p_d[5] = 18'sd128 * bs;
    p_d[6] = 18'sd128 * rs;
    p_d[7] = -18'sd107 * gs;
    p_d[8] = -18'sd21 * bs;
  end
  function automatic logic [7:0] clamp(input logic signed [9:0] v);
    return v[9] ? 8'd0 : (v[8] ? 8'hFF : v[7:0]);
  endfunction
  always_comb begin
    y_c = clamp(y2_q);
    cb_c = clamp(cb2_q);
    cr_c = clamp(cr2_q);
    data_d = m2_q == 2'd0 ? {y_c, y_c, y_c} :
             m2_q == 2'd1 ? {y_c, cb_c, cr_c} :
             m2_q == 2'd2 ? {24{y_c >= t2_q}} : rgb2_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      act_mode_q <= 2'd0;
      act_thresh_q <= 8'd128;
      p_q <= '{default: '0};
      m1_q <= '0;
      m2_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      rgb1_q <= '0;
      rgb2_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      y2_q <= '0;
      cb2_q <= '0;
      cr2_q <= '0;
      y3_q <= '0;
      data3_q <= '0;
    end else begin
      vs_q <= RGB_vsync;
      act_mode_q <= mode_d;
      act_thresh_q <= thresh_d;
      p_q <= p_d;
      m1_q <= mode_d;
      t1_q <= thresh_d;
      rgb1_q <= {r, g, b};
      sync1_q <= {RGB_de, RGB_hsync, RGB_vsync};
      y2_q <= 10'((p_q[0] + p_q[1] + p_q[2] + 18'sd128) >>> 8);
      cb2_q <= 10'((p_q[3] + p_q[4] + p_q[5] + 18'sd32896) >>> 8);
      cr2_q <= 10'((p_q[6] + p_q[7] + p_q[8] + 18'sd32896) >>> 8);
      m2_q <= m1_q;
      t2_q <= t1_q;
      rgb2_q <= rgb1_q;
      sync2_q <= sync1_q;
      y3_q <= y_c;
      data3_q <= sync2_q[2] ? data_d : 24'd0;
      sync3_q <= sync2_q;
    end
  end
  assign {out_de, out_hsync, out_vsync} = sync3_q;
  assign out_data = data3_q;
  logic ovs_q, armed_q, o_rise, valid_q;
  logic [SUM_W:0] acc_w;
  logic [CNT_W:0] cnt_w;
  logic [SUM_W-1:0] acc_q, acc_d, sum_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, lcnt_q;
  always_comb begin
    acc_w = {1'b0, acc_q} + {{(SUM_W - 7){1'b0}}, sync3_q[2] ? y3_q : 8'd0};
    cnt_w = {1'b0, cnt_q} + {{CNT_W{1'b0}}, sync3_q[2]};
    acc_d = acc_w[SUM_W] ? '1 : acc_w[SUM_W-1:0];
    cnt_d = cnt_w[CNT_W] ? '1 : cnt_w[CNT_W-1:0];
    o_rise = sync3_q[0] & ~ovs_q;
  end
  // the first output frame edge after reset only arms, so a partial frame is never reported
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovs_q <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      lcnt_q <= '0;
    end else begin
      ovs_q <= sync3_q[0];
      valid_q <= o_rise & armed_q;
      if (o_rise) begin
        armed_q <= 1'b1;
        acc_q <= '0;
        cnt_q <= '0;
        if (armed_q) begin
          sum_q <= acc_d;
          lcnt_q <= cnt_d;
        end
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
    end
  end
  assign lum_sum = sum_q;
  assign lum_cnt = lcnt_q;
  assign lum_valid = valid_q;
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// tb_rgb2ycbcr_pipe: directed stimulus on RGB565 and RGB888 instances, checked against a frame-level model
module tb_rgb2ycbcr_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] cm = 2'd0;
  logic [7:0] ct = 8'd0;
  logic de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [15:0] d16 = '0;
  logic [23:0] d24 = '0;
  logic a_de, a_hs, a_vs, a_valid, b_de, b_hs, b_vs, b_valid;
  logic [23:0] a_data, b_data;
  logic [31:0] a_sum, b_sum;
  logic [21:0] a_cnt, b_cnt;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  rgb2ycbcr_pipe #(.IN_FMT(0)) u565 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cm), .cfg_thresh(ct),
    .RGB_de(de), .RGB_hsync(hs), .RGB_vsync(vs), .RGB_data(d16),
    .out_de(a_de), .out_hsync(a_hs), .out_vsync(a_vs), .out_data(a_data),
    .lum_sum(a_sum), .lum_cnt(a_cnt), .lum_valid(a_valid));

  rgb2ycbcr_pipe #(.IN_FMT(1)) u888 (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cm), .cfg_thresh(ct),
    .RGB_de(de), .RGB_hsync(hs), .RGB_vsync(vs), .RGB_data(d24),
    .out_de(b_de), .out_hsync(b_hs), .out_vsync(b_vs), .out_data(b_data),
    .lum_sum(b_sum), .lum_cnt(b_cnt), .lum_valid(b_valid));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat8(input int v);
    return v < 0 ? 0 : (v > 255 ? 255 : v);
  endfunction

  function automatic logic [23:0] x565(input logic [15:0] d);
    return {d[15:11], d[13:11], d[10:5], d[6:5], d[4:0], d[2:0]};
  endfunction

  // returns {Y, output word} for one pixel under the given mode/threshold
  function automatic logic [31:0] conv(input logic [23:0] p, input logic [1:0] m, input logic [7:0] t);
    int r, g, b;
    logic [7:0] y, cb, cr;
    logic [23:0] o;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    y = 8'(sat8((77 * r + 150 * g + 29 * b + 128) >>> 8));
    cb = 8'(sat8((32896 - 43 * r - 85 * g + 128 * b) >>> 8));
    cr = 8'(sat8((32896 + 128 * r - 107 * g - 21 * b) >>> 8));
    o = m == 2'd0 ? {y, y, y} : m == 2'd1 ? {y, cb, cr} : m == 2'd2 ? ((y >= t) ? 24'hFFFFFF : 24'h0) : p;
    return {y, o};
  endfunction

  typedef struct packed {
    logic de, hs, vs;
    logic [23:0] d0, d1;
    logic [7:0] y0, y1;
  } ent_t;

  ent_t pipe [3];
  logic [1:0] am;
  logic [7:0] at;
  logic pvs, ovs, armed, evalid;
  logic started = 1'b0;
  longint acc [2], cnt [2];
  logic [31:0] esum [2];
  logic [21:0] ecnt [2];

  always @(posedge clk) begin
    ent_t n, c;
    logic [31:0] w0, w1;
    longint a, q;
    logic orise;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      am = 2'd0;
      at = 8'd128;
      pvs = 1'b0;
      ovs = 1'b0;
      armed = 1'b0;
      evalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        acc[k] = 0;
        cnt[k] = 0;
        esum[k] = '0;
        ecnt[k] = '0;
      end
      started = 1'b1;
    end else begin
      c = pipe[2];
      orise = c.vs && !ovs;
      for (int k = 0; k < 2; k++) begin
        a = acc[k] + (c.de ? longint'(k == 0 ? c.y0 : c.y1) : 0);
        q = cnt[k] + (c.de ? 1 : 0);
        if (a > 64'hFFFFFFFF) a = 64'hFFFFFFFF;
        if (q > 64'h3FFFFF) q = 64'h3FFFFF;
        if (orise) begin
          if (armed) begin
            esum[k] = 32'(a);
            ecnt[k] = 22'(q);
          end
          acc[k] = 0;
          cnt[k] = 0;
        end else begin
          acc[k] = a;
          cnt[k] = q;
        end
      end
      evalid = orise && armed;
      if (orise) armed = 1'b1;
      ovs = c.vs;
      if (vs && !pvs) begin
        am = cm;
        at = ct;
      end
      pvs = vs;
      w0 = conv(x565(d16), am, at);
      w1 = conv(d24, am, at);
      n.de = de;
      n.hs = hs;
      n.vs = vs;
      n.d0 = de ? w0[23:0] : 24'd0;
      n.d1 = de ? w1[23:0] : 24'd0;
      n.y0 = w0[31:24];
      n.y1 = w1[31:24];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("de565", a_de, pipe[2].de);
      chk("hs565", a_hs, pipe[2].hs);
      chk("vs565", a_vs, pipe[2].vs);
      chk("data565", a_data, pipe[2].d0);
      chk("valid565", a_valid, evalid);
      chk("sum565", a_sum, esum[0]);
      chk("cnt565", a_cnt, ecnt[0]);
      chk("de888", b_de, pipe[2].de);
      chk("vs888", b_vs, pipe[2].vs);
      chk("data888", b_data, pipe[2].d1);
      chk("valid888", b_valid, evalid);
      chk("sum888", b_sum, esum[1]);
      chk("cnt888", b_cnt, ecnt[1]);
    end
  end

  task automatic send(input logic [15:0] p16, input logic [23:0] p24, input logic e, input logic h, input logic v);
    d16 = p16;
    d24 = p24;
    de = e;
    hs = h;
    vs = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send(16'h0, 24'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // rise, hold, two idles: afterwards lum_valid of this edge is visible
  task automatic frame_edge();
    send(16'h0, 24'h0, 1'b0, 1'b0, 1'b1);
    send(16'h0, 24'h0, 1'b0, 1'b0, 1'b1);
    idle();
    idle();
  endtask

  initial begin
    repeat (3) idle();
    chk("rst_data", a_data, 24'h0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_sum", a_sum, 32'd0);
    rst_n = 1'b1;
    send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    send(16'h8410, 24'h808080, 1'b1, 1'b0, 1'b0);
    idle();
    cm = 2'd1;
    frame_edge();
    chk("first_edge_no_valid", a_valid, 1'b0);
    cm = 2'd0;
    send(16'hFFFF, 24'h102030, 1'b1, 1'b1, 1'b0);
    send(16'hF800, 24'hFF0000, 1'b1, 1'b1, 1'b0);
    send(16'h001F, 24'h0000FF, 1'b1, 1'b1, 1'b0);
    chk("ycc_white", a_data, 24'hFF8080);
    chk("ycc_white_de", a_de, 1'b1);
    chk("ycc_white_hs", a_hs, 1'b1);
    send(16'h0000, 24'h7A3C91, 1'b1, 1'b1, 1'b0);
    chk("ycc_red", a_data, 24'h4D55FF);
    idle();
    chk("ycc_blue", a_data, 24'h1DFF6B);
    idle();
    chk("ycc_black", a_data, 24'h008080);
    idle();
    chk("ycc_gap_data", a_data, 24'h0);
    chk("ycc_gap_de", a_de, 1'b0);
    frame_edge();
    chk("f1_valid", a_valid, 1'b1);
    chk("f1_sum", a_sum, 32'd361);
    chk("f1_cnt", a_cnt, 22'd4);
    idle();
    chk("f1_valid_pulse", a_valid, 1'b0);
    chk("f1_sum_hold", a_sum, 32'd361);
    repeat (4) send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    repeat (2) send(16'hF800, 24'hFF0000, 1'b1, 1'b0, 1'b0);
    idle();
    chk("gray_red", a_data, 24'h4D4D4D);
    idle();
    idle();
    cm = 2'd2;
    ct = 8'd77;
    frame_edge();
    chk("f2_valid", a_valid, 1'b1);
    chk("f2_sum", a_sum, 32'd1174);
    chk("f2_cnt", a_cnt, 22'd6);
    send(16'hF800, 24'hFF0000, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("bin_t77", a_data, 24'hFFFFFF);
    ct = 8'd78;
    send(16'hF800, 24'hFF0000, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("bin_t78_unlatched", a_data, 24'hFFFFFF);
    frame_edge();
    chk("f3_sum", a_sum, 32'd154);
    send(16'hF800, 24'hFF0000, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("bin_t78", a_data, 24'h000000);
    chk("bin_t78_de", a_de, 1'b1);
    cm = 2'd0;
    frame_edge();
    send(16'hF800, 24'h00FF00, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("mode0_red", a_data, 24'h4D4D4D);
    cm = 2'd1;
    send(16'hF800, 24'h00FF00, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("mode_hold_midframe", a_data, 24'h4D4D4D);
    frame_edge();
    send(16'hF800, 24'h00FF00, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("mode_switched", a_data, 24'h4D55FF);
    frame_edge();
    chk("f4_sum", a_sum, 32'd77);
    repeat (4) send(16'h1234, 24'h55AA55, 1'b0, 1'b1, 1'b0);
    frame_edge();
    chk("empty_valid", a_valid, 1'b1);
    chk("empty_sum", a_sum, 32'd0);
    chk("empty_cnt", a_cnt, 22'd0);
    cm = 2'd3;
    frame_edge();
    send(16'hF800, 24'h123456, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("bypass888", b_data, 24'h123456);
    chk("bypass565", a_data, 24'hFF0000);
    send(16'hFFFF, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    chk("bypass888_no_de", b_data, 24'h0);
    chk("bypass565_no_de", a_data, 24'h0);
    frame_edge();
    chk("f5_sum", a_sum, 32'd77);
    send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
    send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
    chk("midrst_data", a_data, 24'h0);
    chk("midrst_de", a_de, 1'b0);
    chk("midrst_hs", a_hs, 1'b0);
    chk("midrst_sum", a_sum, 32'd0);
    chk("midrst_cnt", a_cnt, 22'd0);
    chk("midrst_888", b_data, 24'h0);
    send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    send(16'hFFFF, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    chk("post_rst_gray", a_data, 24'hFFFFFF);
    frame_edge();
    chk("post_rst_no_valid", a_valid, 1'b0);
    repeat (2) send(16'hF800, 24'hFF0000, 1'b1, 1'b0, 1'b0);
    idle();
    frame_edge();
    chk("post_rst_valid", a_valid, 1'b1);
    chk("post_rst_sum", a_sum, 32'd154);
    chk("post_rst_cnt", a_cnt, 22'd2);
    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
